// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution stage: ALUOP codes, issue-word
// field offsets and the result-queue entry layout.
package alu_pkg;

  // ALUOP encoding; codes 11..15 are unused and produce zero.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASS2 = 4'd10;

  // Issue word layout (127 bits, fixed by the reservation station).
  localparam int ISSUE_W         = 127;
  localparam int ISS_TAG_W       = 8;
  localparam int ISS_WORD_W      = 32;
  localparam int ISS_OP_W        = 4;
  localparam int ISS_SRC2_LSB    = 119;
  localparam int ISS_SRC1_LSB    = 111;
  localparam int ISS_INST_LSB    = 79;
  localparam int ISS_VALID_BIT   = 78;
  localparam int ISS_PC_LSB      = 46;
  localparam int ISS_RD_LSB      = 38;
  localparam int ISS_OP_LSB      = 34;
  localparam int ISS_SRC1SEL_BIT = 33;
  localparam int ISS_SRC2SEL_BIT = 32;
  localparam int ISS_IMM_LSB     = 0;

  // Result-queue entry at the default widths (PHY_W=8, XLEN=32).
  typedef struct packed {
    logic [7:0]  dest;
    logic [31:0] data;
    logic [31:0] inst_num;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Circular result queue with extended-pointer full/empty detection.
// Flush empties the queue; storage is cleared only by reset so the head
// reads as zero out of reset.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dropped
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status, head data and the accept/drop decision for this cycle.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count   = wr_ptr - rd_ptr;
    rd_data = mem[rd_ptr[AW-1:0]];
    do_pop  = pop && !empty && !flush;
    do_push = push && !flush && (!full || do_pop);
    dropped = push && !flush && full && !do_pop;
  end

  // Pointer and storage update; a flush discards everything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage: register-read (RR) latch of the issue word, PRF read,
// combinational ALU, and a result queue that feeds the ALU result bus under
// CDB arbiter grant.
// Optional feature macro: ALU_SELF_BYPASS_EN -- forward the entry popped on
// the previous edge to EX operands whose tag matches, covering the PRF write
// that has not landed yet.
module alu_exec_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int PHY_W      = 8,
  parameter int XLEN       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [126:0]     issue_pkt,
  output logic [PHY_W-1:0] prf_raddr1,
  output logic [PHY_W-1:0] prf_raddr2,
  input  logic [XLEN-1:0]  prf_rdata1,
  input  logic [XLEN-1:0]  prf_rdata2,
  input  logic             cdb_grant,
  output logic             alu_result_valid,
  output logic [PHY_W-1:0] alu_result_dest,
  output logic [XLEN-1:0]  alu_result_data,
  output logic [31:0]      alu_result_inst_num,
  output logic             alu_busy,
  output logic             overflow_err
);

  import alu_pkg::*;

  localparam int ENTRY_W = PHY_W + XLEN + 32;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BUSY_LEVEL = CNT_W'(FIFO_DEPTH - 1);

  // RR stage registers
  logic             rr_valid;
  logic [PHY_W-1:0] rr_src1;
  logic [PHY_W-1:0] rr_src2;
  logic [PHY_W-1:0] rr_rd;
  logic [31:0]      rr_inst;
  logic [XLEN-1:0]  rr_pc;
  logic [XLEN-1:0]  rr_imm;
  logic [3:0]       rr_op;
  logic             rr_sel1;
  logic             rr_sel2;

  logic [XLEN-1:0]    src1_data;
  logic [XLEN-1:0]    src2_data;
  logic [XLEN-1:0]    op1;
  logic [XLEN-1:0]    op2;
  logic [XLEN-1:0]    ex_result;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               q_empty;
  logic               q_full;
  logic [CNT_W-1:0]   q_count;
  logic               q_dropped;
  logic               pop_fire;

  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [4:0]      sh;
    logic [XLEN-1:0] r;
    sh = b[4:0];
    r  = '0;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_SLL:   r = a << sh;
      ALU_SLT:   r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:   r = a ^ b;
      ALU_SRL:   r = a >> sh;
      ALU_SRA:   r = $signed(a) >>> sh;
      ALU_OR:    r = a | b;
      ALU_AND:   r = a & b;
      ALU_PASS2: r = b;
      default:   r = '0;
    endcase
    return r;
  endfunction

  // RR latch: capture the issue word when valid; reset/flush squash it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_valid <= 1'b0;
      rr_src1  <= '0;
      rr_src2  <= '0;
      rr_rd    <= '0;
      rr_inst  <= '0;
      rr_pc    <= '0;
      rr_imm   <= '0;
      rr_op    <= '0;
      rr_sel1  <= 1'b0;
      rr_sel2  <= 1'b0;
    end else if (flush) begin
      rr_valid <= 1'b0;
    end else if (issue_pkt[ISS_VALID_BIT]) begin
      rr_valid <= 1'b1;
      rr_src1  <= PHY_W'(issue_pkt[ISS_SRC1_LSB +: ISS_TAG_W]);
      rr_src2  <= PHY_W'(issue_pkt[ISS_SRC2_LSB +: ISS_TAG_W]);
      rr_rd    <= PHY_W'(issue_pkt[ISS_RD_LSB +: ISS_TAG_W]);
      rr_inst  <= issue_pkt[ISS_INST_LSB +: ISS_WORD_W];
      rr_pc    <= XLEN'(issue_pkt[ISS_PC_LSB +: ISS_WORD_W]);
      rr_imm   <= XLEN'(issue_pkt[ISS_IMM_LSB +: ISS_WORD_W]);
      rr_op    <= issue_pkt[ISS_OP_LSB +: ISS_OP_W];
      rr_sel1  <= issue_pkt[ISS_SRC1SEL_BIT];
      rr_sel2  <= issue_pkt[ISS_SRC2SEL_BIT];
    end else begin
      rr_valid <= 1'b0;
    end
  end

  assign prf_raddr1 = rr_src1;
  assign prf_raddr2 = rr_src2;
  assign pop_fire   = alu_result_valid && cdb_grant && !flush;

`ifdef ALU_SELF_BYPASS_EN
  logic             byp_valid;
  logic [PHY_W-1:0] byp_dest;
  logic [XLEN-1:0]  byp_data;

  // Remember the entry broadcast on the last edge; its PRF write is still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      byp_valid <= 1'b0;
      byp_dest  <= '0;
      byp_data  <= '0;
    end else begin
      byp_valid <= pop_fire;
      if (pop_fire) begin
        byp_dest <= alu_result_dest;
        byp_data <= alu_result_data;
      end
    end
  end

  // Register sources, preferring the just-broadcast value on a tag match.
  always_comb begin
    src1_data = (byp_valid && rr_src1 == byp_dest) ? byp_data : prf_rdata1;
    src2_data = (byp_valid && rr_src2 == byp_dest) ? byp_data : prf_rdata2;
  end
`else
  // Register sources straight from the PRF (write-before-read).
  always_comb begin
    src1_data = prf_rdata1;
    src2_data = prf_rdata2;
  end
`endif

  // Operand select, ALU evaluation and queue entry packing.
  always_comb begin
    op1        = rr_sel1 ? rr_pc  : src1_data;
    op2        = rr_sel2 ? rr_imm : src2_data;
    ex_result  = alu_compute(rr_op, op1, op2);
    push_entry = {rr_rd, ex_result, rr_inst};
  end

  alu_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_result_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (rr_valid),
    .wr_data (push_entry),
    .pop     (cdb_grant),
    .rd_data (head_entry),
    .empty   (q_empty),
    .full    (q_full),
    .count   (q_count),
    .dropped (q_dropped)
  );

  // Queue head drives the result bus directly.
  always_comb begin
    alu_result_valid    = !q_empty;
    alu_result_dest     = head_entry[ENTRY_W-1 -: PHY_W];
    alu_result_data     = head_entry[32 +: XLEN];
    alu_result_inst_num = head_entry[31:0];
    alu_busy            = (q_count >= BUSY_LEVEL) || q_full;
  end

  // Sticky drop indicator; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)          overflow_err <= 1'b0;
    else if (q_dropped) overflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus a randomized
// run against a queue-level reference model. The bench plays the PRF.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [126:0] issue_pkt;
  logic [7:0]   prf_raddr1, prf_raddr2;
  logic [31:0]  prf_rdata1, prf_rdata2;
  logic         cdb_grant;
  logic         alu_result_valid;
  logic [7:0]   alu_result_dest;
  logic [31:0]  alu_result_data;
  logic [31:0]  alu_result_inst_num;
  logic         alu_busy;
  logic         overflow_err;

  logic [31:0] prf [256];
  int checks   = 0;
  int failures = 0;

  // Reference model state for the randomized run
  alu_entry_t   exp_q[$];
  logic         m_rr_v;
  logic [126:0] m_rr_pkt;
  logic         m_lp_v;
  alu_entry_t   m_lp;
  logic         m_ovf;

  always #5 clk = ~clk;

  assign prf_rdata1 = prf[prf_raddr1];
  assign prf_rdata2 = prf[prf_raddr2];

  alu_exec_unit #(.FIFO_DEPTH(FIFO_DEPTH), .PHY_W(8), .XLEN(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .issue_pkt           (issue_pkt),
    .prf_raddr1          (prf_raddr1),
    .prf_raddr2          (prf_raddr2),
    .prf_rdata1          (prf_rdata1),
    .prf_rdata2          (prf_rdata2),
    .cdb_grant           (cdb_grant),
    .alu_result_valid    (alu_result_valid),
    .alu_result_dest     (alu_result_dest),
    .alu_result_data     (alu_result_data),
    .alu_result_inst_num (alu_result_inst_num),
    .alu_busy            (alu_busy),
    .overflow_err        (overflow_err)
  );

  function automatic logic [126:0] mk_pkt(input logic [7:0] s2, input logic [7:0] s1,
                                          input logic [31:0] inst, input logic v,
                                          input logic [31:0] pc, input logic [7:0] rd,
                                          input logic [3:0] op, input logic a1,
                                          input logic a2, input logic [31:0] imm);
    return {s2, s1, inst, v, pc, rd, op, a1, a2, imm};
  endfunction

  // Reference ALU from the opcode table, in plain arithmetic.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    int signed   sa, sb;
    sh = b[4:0];
    sa = a;
    sb = b;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; cdb_grant = 1'b0; issue_pkt = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; cdb_grant = 1'b0;
    issue_pkt = mk_pkt(8'd3, 8'd4, 32'd99, 1'b1, 32'h10, 8'd7, 4'd0, 1'b1, 1'b1, 32'h5);
    @(negedge clk); @(negedge clk);
    checks++; if (alu_result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", alu_result_valid); end
    checks++; if (alu_result_dest !== 8'd0 || alu_result_data !== 32'd0 || alu_result_inst_num !== 32'd0) begin
      failures++; $display("FAIL reset_bus got dest=%0h data=%0h inst=%0h want all 0", alu_result_dest, alu_result_data, alu_result_inst_num); end
    checks++; if (alu_busy !== 1'b0 || overflow_err !== 1'b0) begin
      failures++; $display("FAIL reset_flags got busy=%0b ovf=%0b want 0/0", alu_busy, overflow_err); end
    checks++; if (prf_raddr1 !== 8'd0 || prf_raddr2 !== 8'd0) begin
      failures++; $display("FAIL reset_raddr got %0h/%0h want 0/0", prf_raddr1, prf_raddr2); end
    reset = 1'b0; issue_pkt = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (alu_result_valid !== 1'b0) begin failures++; $display("FAIL reset_discard got valid=%0b want=0", alu_result_valid); end
  endtask

  task automatic test_add();
    prf[5] = 32'd7; prf[6] = 32'd9;
    cdb_grant = 1'b1;
    issue_pkt = mk_pkt(8'd6, 8'd5, 32'd1, 1'b1, 32'h0, 8'd12, 4'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    issue_pkt = '0;
    checks++; if (prf_raddr1 !== 8'd5 || prf_raddr2 !== 8'd6) begin
      failures++; $display("FAIL add_raddr got %0d/%0d want 5/6", prf_raddr1, prf_raddr2); end
    checks++; if (alu_result_valid !== 1'b0) begin failures++; $display("FAIL add_early got valid=%0b want=0", alu_result_valid); end
    @(negedge clk);
    checks++; if (alu_result_valid !== 1'b1 || alu_result_dest !== 8'd12 || alu_result_data !== 32'd16 || alu_result_inst_num !== 32'd1) begin
      failures++; $display("FAIL add_result got v=%0b dest=%0d data=%0d inst=%0d want 1/12/16/1",
                           alu_result_valid, alu_result_dest, alu_result_data, alu_result_inst_num); end
    @(negedge clk);
    checks++; if (alu_result_valid !== 1'b0) begin failures++; $display("FAIL add_onecycle got valid=%0b want=0", alu_result_valid); end
  endtask

  task automatic test_alu_ops();
    logic [126:0] p;
    logic [31:0]  want;
    prf[1] = 32'hFFFF_FFFF; prf[2] = 32'd1; prf[3] = 32'h8000_0000;
    cdb_grant = 1'b1;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin p = mk_pkt(8'd0, 8'd0, 32'd10, 1'b1, 32'h100, 8'd40, 4'd0, 1'b1, 1'b1, 32'h1000); want = 32'h1100; end
        1: begin p = mk_pkt(8'd0, 8'd3, 32'd11, 1'b1, 32'h0, 8'd41, 4'd7, 1'b0, 1'b1, 32'd4); want = 32'hF800_0000; end
        2: begin p = mk_pkt(8'd2, 8'd1, 32'd12, 1'b1, 32'h0, 8'd42, 4'd3, 1'b0, 1'b0, 32'h0); want = 32'd1; end
        3: begin p = mk_pkt(8'd2, 8'd1, 32'd13, 1'b1, 32'h0, 8'd43, 4'd4, 1'b0, 1'b0, 32'h0); want = 32'd0; end
        4: begin p = mk_pkt(8'd1, 8'd2, 32'd14, 1'b1, 32'h0, 8'd44, 4'd1, 1'b0, 1'b0, 32'h0); want = 32'd2; end
        default: begin p = mk_pkt(8'd2, 8'd1, 32'd15, 1'b1, 32'h0, 8'd45, 4'd12, 1'b0, 1'b0, 32'h0); want = 32'd0; end
      endcase
      issue_pkt = p;
      @(negedge clk);
      issue_pkt = '0;
      @(negedge clk);
      checks++; if (alu_result_valid !== 1'b1 || alu_result_data !== want || alu_result_dest !== 8'(40 + k)) begin
        failures++; $display("FAIL alu_op%0d got v=%0b data=%08h dest=%0d want 1/%08h/%0d",
                             k, alu_result_valid, alu_result_data, alu_result_dest, want, 40 + k); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int exp_cnt;
    do_reset();
    cdb_grant = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      issue_pkt = (j <= 5) ? mk_pkt(8'd0, 8'd0, 32'(j), 1'b1, 32'h0, 8'(30 + j), 4'd10, 1'b0, 1'b1, 32'(100 + j)) : '0;
      @(negedge clk);
      exp_cnt = (j - 1 > 4) ? 4 : j - 1;
      checks++; if (alu_busy !== (exp_cnt >= 3) || alu_result_valid !== (exp_cnt > 0) || overflow_err !== (j == 6)) begin
        failures++; $display("FAIL bp_fill%0d got busy=%0b v=%0b ovf=%0b want %0b/%0b/%0b",
                             j, alu_busy, alu_result_valid, overflow_err, exp_cnt >= 3, exp_cnt > 0, j == 6); end
    end
    cdb_grant = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (alu_result_valid !== 1'b1 || alu_result_data !== 32'(100 + k) || alu_result_dest !== 8'(30 + k) || alu_result_inst_num !== 32'(k)) begin
        failures++; $display("FAIL bp_drain%0d got v=%0b data=%0d dest=%0d inst=%0d want 1/%0d/%0d/%0d",
                             k, alu_result_valid, alu_result_data, alu_result_dest, alu_result_inst_num, 100 + k, 30 + k, k); end
      @(negedge clk);
    end
    checks++; if (alu_result_valid !== 1'b0 || overflow_err !== 1'b1) begin
      failures++; $display("FAIL bp_empty got v=%0b ovf=%0b want 0/1", alu_result_valid, overflow_err); end
  endtask

  task automatic test_flush();
    cdb_grant = 1'b0;
    for (int j = 0; j < 3; j++) begin
      issue_pkt = mk_pkt(8'd0, 8'd0, 32'(50 + j), 1'b1, 32'h0, 8'(50 + j), 4'd10, 1'b0, 1'b1, 32'(32'h51 + j));
      @(negedge clk);
    end
    checks++; if (alu_result_valid !== 1'b1 || alu_result_inst_num !== 32'd50) begin
      failures++; $display("FAIL flush_pre got v=%0b inst=%0d want 1/50", alu_result_valid, alu_result_inst_num); end
    flush = 1'b1; cdb_grant = 1'b1;
    issue_pkt = mk_pkt(8'd0, 8'd0, 32'd55, 1'b1, 32'h0, 8'd55, 4'd10, 1'b0, 1'b1, 32'h55);
    @(negedge clk);
    flush = 1'b0;
    checks++; if (alu_result_valid !== 1'b0 || alu_busy !== 1'b0 || overflow_err !== 1'b1) begin
      failures++; $display("FAIL flush_clear got v=%0b busy=%0b ovf=%0b want 0/0/1", alu_result_valid, alu_busy, overflow_err); end
    issue_pkt = mk_pkt(8'd0, 8'd0, 32'd60, 1'b1, 32'h0, 8'd9, 4'd10, 1'b0, 1'b1, 32'h61);
    @(negedge clk);
    issue_pkt = '0;
    checks++; if (alu_result_valid !== 1'b0) begin failures++; $display("FAIL flush_lat1 got v=%0b want 0", alu_result_valid); end
    @(negedge clk);
    checks++; if (alu_result_valid !== 1'b1 || alu_result_data !== 32'h61 || alu_result_inst_num !== 32'd60 || alu_result_dest !== 8'd9) begin
      failures++; $display("FAIL flush_after got v=%0b data=%0h inst=%0d dest=%0d want 1/61/60/9",
                           alu_result_valid, alu_result_data, alu_result_inst_num, alu_result_dest); end
    @(negedge clk);
    checks++; if (alu_result_valid !== 1'b0) begin failures++; $display("FAIL flush_leftover got v=%0b want 0", alu_result_valid); end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
`ifdef ALU_SELF_BYPASS_EN
    want = 32'hAA;
`else
    want = 32'h0;
`endif
    do_reset();
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL byp_ovf_reset got=%0b want=0", overflow_err); end
    prf[20] = 32'h0;
    issue_pkt = mk_pkt(8'd0, 8'd0, 32'd70, 1'b1, 32'h0, 8'd20, 4'd10, 1'b0, 1'b1, 32'hAA);
    @(negedge clk);
    issue_pkt = '0;
    @(negedge clk);
    checks++; if (alu_result_valid !== 1'b1 || alu_result_dest !== 8'd20) begin
      failures++; $display("FAIL byp_head got v=%0b dest=%0d want 1/20", alu_result_valid, alu_result_dest); end
    cdb_grant = 1'b1;
    issue_pkt = mk_pkt(8'd0, 8'd20, 32'd71, 1'b1, 32'h0, 8'd21, 4'd0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    issue_pkt = '0;
    @(negedge clk);
    checks++; if (alu_result_valid !== 1'b1 || alu_result_dest !== 8'd21 || alu_result_data !== want) begin
      failures++; $display("FAIL byp_result got v=%0b dest=%0d data=%0h want 1/21/%0h",
                           alu_result_valid, alu_result_dest, alu_result_data, want); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [126:0] p;
    logic         g, f, pop;
    logic         was_full;
    alu_entry_t   e;
    logic [31:0]  a, b;
    for (int i = 0; i < 256; i++) prf[i] = $urandom;
    do_reset();
    exp_q.delete(); m_rr_v = 1'b0; m_lp_v = 1'b0; m_ovf = 1'b0; m_rr_pkt = '0; m_lp = '0;
    for (int i = 0; i < 400; i++) begin
      p = mk_pkt(8'($urandom), 8'($urandom), 32'(1000 + i), ($urandom_range(3) != 0), $urandom,
                 8'($urandom), 4'($urandom_range(15)), 1'($urandom), 1'($urandom),
                 ($urandom_range(1) != 0) ? 32'($urandom_range(63)) : $urandom);
      g = (i < 200) ? ($urandom_range(2) == 0) : ($urandom_range(7) != 0);
      f = ($urandom_range(39) == 0);
      issue_pkt = p; cdb_grant = g; flush = f;
      @(posedge clk);
      if (f) begin
        exp_q.delete(); m_rr_v = 1'b0; m_lp_v = 1'b0;
      end else begin
        a = m_rr_pkt[33] ? m_rr_pkt[77:46] : prf[m_rr_pkt[118:111]];
        b = m_rr_pkt[32] ? m_rr_pkt[31:0]  : prf[m_rr_pkt[126:119]];
`ifdef ALU_SELF_BYPASS_EN
        if (!m_rr_pkt[33] && m_lp_v && m_lp.dest == m_rr_pkt[118:111]) a = m_lp.data;
        if (!m_rr_pkt[32] && m_lp_v && m_lp.dest == m_rr_pkt[126:119]) b = m_lp.data;
`endif
        e.dest = m_rr_pkt[45:38];
        e.data = ref_alu(int'(m_rr_pkt[37:34]), a, b);
        e.inst_num = m_rr_pkt[110:79];
        was_full = (exp_q.size() == FIFO_DEPTH);
        pop = (exp_q.size() > 0) && g;
        if (pop) begin m_lp_v = 1'b1; m_lp = exp_q.pop_front(); end
        else m_lp_v = 1'b0;
        if (m_rr_v) begin
          if (was_full && !pop) m_ovf = 1'b1;
          else exp_q.push_back(e);
        end
        m_rr_v = p[78]; m_rr_pkt = p;
      end
      @(negedge clk);
      checks++; if (alu_result_valid !== (exp_q.size() > 0) || alu_busy !== (exp_q.size() >= FIFO_DEPTH - 1) || overflow_err !== m_ovf) begin
        failures++; $display("FAIL rand%0d_flags got v=%0b busy=%0b ovf=%0b want %0b/%0b/%0b", i,
                             alu_result_valid, alu_busy, overflow_err, exp_q.size() > 0, exp_q.size() >= FIFO_DEPTH - 1, m_ovf); end
      if (exp_q.size() > 0) begin
        checks++; if (alu_result_dest !== exp_q[0].dest || alu_result_data !== exp_q[0].data || alu_result_inst_num !== exp_q[0].inst_num) begin
          failures++; $display("FAIL rand%0d_head got dest=%0h data=%08h inst=%0d want %0h/%08h/%0d", i,
                               alu_result_dest, alu_result_data, alu_result_inst_num, exp_q[0].dest, exp_q[0].data, exp_q[0].inst_num); end
      end
    end
    flush = 1'b0; issue_pkt = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prf[i] = 32'h0;
    reset = 1'b1; flush = 1'b0; cdb_grant = 1'b0; issue_pkt = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_alu_ops();
    test_backpressure();
    test_flush();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution stage directly downstream of the ALU reservation station in the out-of-order core. It accepts the station's packed 127-bit issue word, reads both source operands from the physical register file (PRF), and computes the ALU result. It then queues the result and broadcasts it to the PRF and to every reservation station as the ALU result bus (`alu_result_valid` / `alu_result_dest`), under a grant from the common-data-bus arbiter.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: number of result-queue entries; must be a power of two and at least 2.
- `PHY_W`, default 8: physical-tag width.
- `XLEN`, default 32: data width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: exception or mret; synchronous squash.
- `issue_pkt` in 127: issue word. Fields:
  - [126:119] src2 tag
  - [118:111] src1 tag
  - [110:79] inst_num
  - [78] valid
  - [77:46] PC
  - [45:38] Rd (physical)
  - [37:34] ALUOP
  - [33] ALUSrc1
  - [32] ALUSrc2
  - [31:0] imm
- `prf_raddr1`, `prf_raddr2` out PHY_W: PRF read addresses.
- `prf_rdata1`, `prf_rdata2` in XLEN: combinational PRF read data, valid in the same cycle as the address.
- `cdb_grant` in 1: arbiter accepts the current broadcast.
- `alu_result_valid` out 1: broadcast valid.
- `alu_result_dest` out PHY_W: destination tag.
- `alu_result_data` out XLEN: result value.
- `alu_result_inst_num` out 32: instruction number for the ROB.
- `alu_busy` out 1: result queue count ≥ FIFO_DEPTH−1; the reservation station must not issue while this is high.
- `overflow_err` out 1: sticky; set when an instruction is dropped because the queue is full.

## Operation
- The block is two register stages: RR (register read), then EX, which writes the result into the queue.
- **RR capture:** when `issue_pkt[78]`=1, all fields are latched and `rr_valid` is set; otherwise `rr_valid` is cleared.
- **Read addresses:** `prf_raddr1`/`prf_raddr2` are driven from the latched src1/src2 tags during the RR cycle.
- **Operand mux:**
  - op1 = ALUSrc1 ? PC : `prf_rdata1`
  - op2 = ALUSrc2 ? imm : `prf_rdata2`
- **ALUOP encoding:**
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS2 (LUI).
  - Codes 11–15 produce result 0.
- **Arithmetic:**
  - Shift amount is op2[4:0].
  - Add/sub wrap modulo 2^XLEN.
  - SLT/SLTU return 0 or 1, zero-extended.
- **Queue push:** on an edge where `rr_valid`=1, the entry {Rd, result, inst_num} is pushed into the circular queue.
- **Queue head:** drives the broadcast outputs combinationally; `alu_result_valid` = queue not empty.
- **Queue pop:** occurs on any edge with `alu_result_valid`=1 and `cdb_grant`=1.
- **Full queue:**
  - A simultaneous push and pop while full is legal; count is unchanged.
  - A push while full with no pop is dropped and sets `overflow_err`.
- **Pointers:** log2(FIFO_DEPTH)+1 bits; full when the MSBs differ and the low bits are equal; wrap-around is natural.

## Timing
- **Issue-to-broadcast latency:** issue word sampled at edge N, result enters the queue at edge N+1, and `alu_result_valid` is high from edge N+1 when the queue was empty. Latency is 2 edges.
- **Throughput:** one instruction per cycle while `cdb_grant` stays high.
- **Reset values:** all outputs are 0; queue empty; `rr_valid`=0; `overflow_err`=0.
- **Reset or flush at edge E:**
  - Clears `rr_valid` and empties the queue.
  - Any issue word presented at E is discarded.
  - `alu_result_valid`=0 in the cycle after E.
  - `overflow_err` is cleared by reset only.
- **Flush and grant at the same edge:** the flush wins; a grant in that cycle has no effect beyond the flush.

## Configuration
- **`ALU_SELF_BYPASS_EN` defined:**
  - In EX, if a source tag equals the tag of the entry popped on the previous edge, EX uses that entry's data instead of `prf_rdata`.
  - This covers a PRF write that has not landed.
  - Only applies when the operand's ALUSrc bit is 0.
- **`ALU_SELF_BYPASS_EN` undefined:** operands come only from the PRF or PC/imm; the PRF must be write-before-read.

## Structure
- Shared package `alu_pkg` holds:
  - ALUOP localparams (ALU_ADD … ALU_PASS2)
  - issue-word field offsets
  - the result-entry struct {dest, data, inst_num}
- Sub-module `alu_result_fifo` provides the parameterised circular queue with count and full/empty. The compute logic is a combinational function in the top module.

## Test plan
- ADD: issue ALUOP=0, ALUSrc=0/0, PRF[5]=7, PRF[6]=9, Rd=12, grant=1 → 2 edges later `alu_result_valid`=1, dest=12, data=16 for one cycle.
- AUIPC/SRA/SLT: PC=0x100, imm=0x1000 with ALUSrc1=1, ALUSrc2=1, ALUOP=0 → 0x1100. ALUOP=7 with op1=0x80000000, shamt=4 → 0xF8000000. SLT(−1, 1) → 1; SLTU(−1, 1) → 0.
- Backpressure: `cdb_grant`=0, issue 5 back-to-back → `alu_busy` rises after 3 results are queued; the 5th result is dropped and `overflow_err`=1. Then grant=1 → results 1–4 emerge in order.
- Flush: 2 results queued and 1 in RR, assert `flush` → next cycle `alu_result_valid`=0. A new issue afterwards completes normally with latency 2.
- Bypass (macro on): pop dest=20 data=0xAA; the next instruction's src1=20 while PRF[20]=0 → result uses 0xAA. With the macro off → result uses 0.
